// File: rtl/switch_ingress_writer_pkg.sv
// Shared definitions for the ingress writer and for the requester that unpacks its sideband entries.
// Both sides pack and unpack through the helpers below, so the field layout is defined once.
package switch_ingress_writer_pkg;

  localparam int AXIS_DEST_WIDTH = 2;
  localparam int SIDEBAND_WIDTH  = 20;
  localparam int SB_PTR_WIDTH    = SIDEBAND_WIDTH - AXIS_DEST_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_REWIND  = 3'd4,
    ST_DISCARD = 3'd5
  } wr_state_t;

  typedef logic [SIDEBAND_WIDTH-1:0] sideband_t;

  // The start pointer is zero-extended into the upper field; dest sits in the low bits.
  function automatic sideband_t pack_sideband(input logic [SB_PTR_WIDTH-1:0]    start_ptr,
                                              input logic [AXIS_DEST_WIDTH-1:0] dest);
    return {start_ptr, dest};
  endfunction

  function automatic logic [SB_PTR_WIDTH-1:0] sideband_ptr(input sideband_t entry);
    return entry[SIDEBAND_WIDTH-1:AXIS_DEST_WIDTH];
  endfunction

  function automatic logic [AXIS_DEST_WIDTH-1:0] sideband_dest(input sideband_t entry);
    return entry[AXIS_DEST_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/switch_ingress_writer_frame_stat_counters.sv
// Committed / dropped frame statistics; both counters wrap silently.
module frame_stat_counters #(
  parameter int CTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit_inc,
  input  logic                 drop_inc,
  output logic [CTR_WIDTH-1:0] committed_count,
  output logic [CTR_WIDTH-1:0] dropped_count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      committed_count <= '0;
      dropped_count   <= '0;
    end else begin
      if (commit_inc) committed_count <= committed_count + CTR_WIDTH'(1);
      if (drop_inc)   dropped_count   <= dropped_count + CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/switch_ingress_writer.sv
// Writes one ingress frame at a time into the frame buffer, then commits it to the sideband
// queue or rewinds the buffer write cursor, depending on the filter verdict.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for the first beat of a frame
// HEADER     | writing beats, waiting for the filter verdict
// COMMIT     | verdict forward: push {start_ptr, dest} when sideband has room
// PAYLOAD    | committed frame: write remaining beats up to tlast
// REWIND     | verdict drop: pulse frame_wrst back to the frame start
// DISCARD    | dropped frame: swallow remaining beats up to tlast
module switch_ingress_writer
  import switch_ingress_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int CTR_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                ingress_tdata,
  input  logic                       ingress_tvalid,
  input  logic                       ingress_tlast,
  output logic                       ingress_tready,
  input  logic                       filter_valid,
  input  logic                       filter_drop,
  input  logic [AXIS_DEST_WIDTH-1:0] filter_dest,
  input  logic [ADDR_WIDTH:0]        frame_wptr,
  input  logic                       frame_full,
  output logic                       frame_wen,
  output logic [15:0]                frame_wdata,
  output logic                       frame_wrst,
  output logic [ADDR_WIDTH:0]        frame_rst_wptr,
  input  logic                       sideband_full,
  output logic                       sideband_wen,
  output logic [SIDEBAND_WIDTH-1:0]  sideband_wdata,
  output logic                       scan_payload,
  output logic [CTR_WIDTH-1:0]       committed_count,
  output logic [CTR_WIDTH-1:0]       dropped_count
);

  wr_state_t                  state;
  logic [ADDR_WIDTH:0]        start_ptr;
  logic [AXIS_DEST_WIDTH-1:0] dest_q;
  logic                       done;
  logic                       scan_q;
  logic                       ready_raw;
  logic                       write_state;
  logic                       beat_ok;

  always_comb begin
    ready_raw = 1'b0;
    case (state)
      ST_IDLE:    ready_raw = ~frame_full;
      ST_HEADER:  ready_raw = ~frame_full & ~done;
      ST_PAYLOAD: ready_raw = ~frame_full;
      ST_DISCARD: ready_raw = 1'b1;
      default:    ready_raw = 1'b0;
    endcase
  end

  // Gating with reset keeps tready low while reset is held, independent of frame_full.
  assign ingress_tready = reset & ready_raw;
  assign beat_ok        = ingress_tvalid & ingress_tready;
  assign write_state    = (state == ST_IDLE) | (state == ST_HEADER) | (state == ST_PAYLOAD);

  assign frame_wen      = beat_ok & write_state;
  assign frame_wdata    = ingress_tdata;
  assign frame_wrst     = (state == ST_REWIND);
  assign frame_rst_wptr = start_ptr;
  assign sideband_wen   = (state == ST_COMMIT) & ~sideband_full;
  assign sideband_wdata = pack_sideband(SB_PTR_WIDTH'(start_ptr), dest_q);
  assign scan_payload   = scan_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      start_ptr <= '0;
      dest_q    <= '0;
      done      <= 1'b0;
      scan_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (beat_ok) begin
            start_ptr <= frame_wptr;
            scan_q    <= 1'b0;
            done      <= ingress_tlast;
            state     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          // A beat accepted alongside the verdict is already written; its tlast still counts.
          if (beat_ok && ingress_tlast) done <= 1'b1;
          if (filter_valid) begin
            dest_q <= filter_dest;
            state  <= filter_drop ? ST_REWIND : ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (!sideband_full) begin
            scan_q <= 1'b1;
            state  <= done ? ST_IDLE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (beat_ok && ingress_tlast) state <= ST_IDLE;
        end
        ST_REWIND: begin
          state <= done ? ST_IDLE : ST_DISCARD;
        end
        ST_DISCARD: begin
          if (beat_ok && ingress_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  frame_stat_counters #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_stats (
    .clk             (clk),
    .reset           (reset),
    .commit_inc      (sideband_wen),
    .drop_inc        (frame_wrst),
    .committed_count (committed_count),
    .dropped_count   (dropped_count)
  );

endmodule

// File: tb/tb_switch_ingress_writer.sv
// Self-checking bench for switch_ingress_writer: frame-level table vectors, a mid-frame reset
// sequence, and randomized frames checked against a per-frame reference model.
module tb_switch_ingress_writer;
  import switch_ingress_writer_pkg::*;

  localparam int AW = 11;
  localparam int CW = 16;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [15:0]                ingress_tdata;
  logic                       ingress_tvalid;
  logic                       ingress_tlast;
  logic                       ingress_tready;
  logic                       filter_valid;
  logic                       filter_drop;
  logic [AXIS_DEST_WIDTH-1:0] filter_dest;
  logic [AW:0]                frame_wptr;
  logic                       frame_full;
  logic                       frame_wen;
  logic [15:0]                frame_wdata;
  logic                       frame_wrst;
  logic [AW:0]                frame_rst_wptr;
  logic                       sideband_full;
  logic                       sideband_wen;
  logic [SIDEBAND_WIDTH-1:0]  sideband_wdata;
  logic                       scan_payload;
  logic [CW-1:0]              committed_count;
  logic [CW-1:0]              dropped_count;

  always #5 clk = ~clk;

  switch_ingress_writer #(.ADDR_WIDTH(AW), .CTR_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ingress_tdata   (ingress_tdata),
    .ingress_tvalid  (ingress_tvalid),
    .ingress_tlast   (ingress_tlast),
    .ingress_tready  (ingress_tready),
    .filter_valid    (filter_valid),
    .filter_drop     (filter_drop),
    .filter_dest     (filter_dest),
    .frame_wptr      (frame_wptr),
    .frame_full      (frame_full),
    .frame_wen       (frame_wen),
    .frame_wdata     (frame_wdata),
    .frame_wrst      (frame_wrst),
    .frame_rst_wptr  (frame_rst_wptr),
    .sideband_full   (sideband_full),
    .sideband_wen    (sideband_wen),
    .sideband_wdata  (sideband_wdata),
    .scan_payload    (scan_payload),
    .committed_count (committed_count),
    .dropped_count   (dropped_count)
  );

  // One frame scenario: verdict arrives once vat beats are taken, after vdelay idle cycles;
  // gap holds tvalid low in the verdict cycle. exp_writes/exp_push are the expected outcome.
  typedef struct {
    int          beats;
    int          vat;
    int          vdelay;
    bit          gap;
    bit          drop;
    logic [1:0]  dest;
    logic [AW:0] wptr;
    int          sb_full;
    int          ff_at;
    int          ff_len;
    int          exp_writes;
    bit          exp_push;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_c  = 0;
  int exp_d  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int beats, input int vat, input int vdelay, input bit gap,
                              input bit drop, input logic [1:0] dest, input logic [AW:0] wptr,
                              input int sb_full, input int ff_at, input int ff_len,
                              input int exp_writes, input bit exp_push);
    vec_t v;
    v.beats = beats; v.vat = vat; v.vdelay = vdelay; v.gap = gap; v.drop = drop;
    v.dest = dest; v.wptr = wptr; v.sb_full = sb_full; v.ff_at = ff_at; v.ff_len = ff_len;
    v.exp_writes = exp_writes; v.exp_push = exp_push;
    return v;
  endfunction

  // Reference outcome: a forwarded frame writes every beat; a dropped frame writes the beats
  // taken before the verdict plus the beat that shares the verdict cycle, if any.
  function automatic int model_writes(input vec_t v);
    if (!v.drop) return v.beats;
    return v.vat + ((!v.gap && v.vat < v.beats) ? 1 : 0);
  endfunction

  task automatic run_frame(input vec_t v);
    int acc = 0, wait_cnt = 0, sb_cnt = 0, ff_left = 0, post = 0, cyc = 0;
    int n_wen = 0, n_sb = 0, n_wrst = 0, proto_bad = 0, ready_bad = 0, scan_bad = 0;
    int v_cyc = 0, act_cyc = 0;
    bit v_sent = 0, ff_done = 0, act_seen = 0, fire, pausing, scan_exp = 0, finished = 0;
    logic [SIDEBAND_WIDTH-1:0] sb_data = '0;
    logic [SIDEBAND_WIDTH-1:0] exp_sb;
    logic [AW:0] rst_ptr = '0;
    logic [AW:0] wptr_nxt = v.wptr;
    exp_sb = {6'b0, v.wptr, v.dest};
    while (1) begin
      @(posedge clk); #1;
      frame_wptr    = wptr_nxt;
      sideband_full = v_sent && (sb_cnt < v.sb_full);
      if (sideband_full) sb_cnt++;
      fire = 0;
      if (!finished && !v_sent && acc >= v.vat) begin
        if (wait_cnt >= v.vdelay) fire = 1;
        else wait_cnt++;
      end
      pausing = !v_sent && (acc >= v.vat) && !fire;
      if (!finished && v.ff_at > 0 && !ff_done && acc >= v.ff_at) begin
        ff_left = v.ff_len;
        ff_done = 1;
      end
      frame_full = (ff_left > 0);
      if (ff_left > 0) ff_left--;
      filter_valid   = fire;
      filter_drop    = v.drop;
      filter_dest    = v.dest;
      ingress_tvalid = !finished && (acc < v.beats) && !pausing && !(fire && v.gap);
      ingress_tdata  = 16'($urandom);
      ingress_tlast  = (acc == v.beats - 1);
      @(negedge clk);
      if (ingress_tready && !act_seen && (v_sent || acc == v.beats)) ready_bad++;
      if (frame_full && ingress_tready) ready_bad++;
      if (frame_wen && !(ingress_tvalid && ingress_tready)) proto_bad++;
      if (frame_wen && frame_wdata !== ingress_tdata) proto_bad++;
      if (sideband_wen && sideband_full) proto_bad++;
      if (sideband_wen && scan_payload) scan_bad++;
      if (scan_exp && !scan_payload) scan_bad++;
      scan_exp = sideband_wen;
      if (frame_wen) begin n_wen++; wptr_nxt++; end
      if (sideband_wen) begin n_sb++; sb_data = sideband_wdata; act_seen = 1; act_cyc = cyc; end
      if (frame_wrst) begin
        n_wrst++; rst_ptr = frame_rst_wptr; wptr_nxt = frame_rst_wptr; act_seen = 1; act_cyc = cyc;
      end
      if (ingress_tvalid && ingress_tready) acc++;
      if (fire) begin v_sent = 1; v_cyc = cyc; end
      cyc++;
      if (finished) begin
        post++;
        if (post >= 3) break;
      end else if (acc == v.beats && act_seen) begin
        finished = 1;
      end
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL frame_timeout: actual acc=%0d act=%0d, required acc=%0d act=1", acc, act_seen, v.beats);
        break;
      end
    end
    ingress_tvalid = 0; filter_valid = 0; sideband_full = 0; frame_full = 0;
    chk("beats_accepted", acc, v.beats);
    chk("frame_writes", n_wen, v.exp_writes);
    chk("sideband_pushes", n_sb, v.exp_push);
    if (v.exp_push) chk("sideband_data", sb_data, exp_sb);
    chk("rewinds", n_wrst, v.drop);
    if (v.drop) chk("rewind_ptr", rst_ptr, v.wptr);
    chk("action_latency", act_cyc - v_cyc, v.drop ? 1 : v.sb_full + 1);
    if (v.drop) exp_d++; else exp_c++;
    chk("committed_count", committed_count, exp_c % 65536);
    chk("dropped_count", dropped_count, exp_d % 65536);
    chk("scan_payload_end", scan_payload, !v.drop);
    chk("protocol_errs", proto_bad, 0);
    chk("ready_gating_errs", ready_bad, 0);
    chk("scan_timing_errs", scan_bad, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    ingress_tdata = '0; ingress_tvalid = 0; ingress_tlast = 0;
    filter_valid = 0; filter_drop = 0; filter_dest = '0;
    frame_wptr = '0; frame_full = 0; sideband_full = 0;

    //             beats vat dly gap drop dest wptr    sbf ffat fflen writes push
    tbl[0] = mk(4, 1, 0, 0, 0, 2'd2, 12'h010, 0, 0, 0, 4, 1);
    tbl[1] = mk(6, 2, 0, 1, 1, 2'd1, 12'h7FE, 0, 0, 0, 2, 0);
    tbl[2] = mk(2, 2, 5, 0, 0, 2'd1, 12'h100, 0, 0, 0, 2, 1);
    tbl[3] = mk(3, 1, 0, 0, 0, 2'd3, 12'h020, 3, 0, 0, 3, 1);
    tbl[4] = mk(8, 1, 0, 0, 0, 2'd0, 12'h200, 0, 4, 4, 8, 1);
    tbl[5] = mk(5, 2, 0, 0, 1, 2'd2, 12'hFFF, 0, 0, 0, 3, 0);
    tbl[6] = mk(3, 3, 2, 0, 1, 2'd3, 12'h0AB, 0, 0, 0, 3, 0);
    tbl[7] = mk(1, 1, 0, 0, 0, 2'd1, 12'h801, 2, 0, 0, 1, 1);

    repeat (3) @(posedge clk);
    #1 ingress_tvalid = 1;
    @(negedge clk);
    chk("reset_tready", ingress_tready, 0);
    chk("reset_wen", frame_wen, 0);
    chk("reset_scan", scan_payload, 0);
    chk("reset_sideband_wen", sideband_wen, 0);
    chk("reset_counts", {committed_count, dropped_count}, 0);
    ingress_tvalid = 0;
    reset = 1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Reset asserted while the frame is in PAYLOAD.
    @(posedge clk); #1;
    frame_wptr = 12'h055; ingress_tvalid = 1; ingress_tlast = 0; ingress_tdata = 16'h1111;
    @(posedge clk); #1;
    filter_valid = 1; filter_drop = 0; filter_dest = 2'd1; ingress_tdata = 16'h2222;
    @(posedge clk); #1;
    filter_valid = 0;
    @(posedge clk); #1;
    ingress_tdata = 16'h3333;
    @(negedge clk);
    exp_c++;
    chk("pre_reset_scan", scan_payload, 1);
    chk("pre_reset_committed", committed_count, exp_c % 65536);
    #2 reset = 0;
    #1;
    chk("async_rst_tready", ingress_tready, 0);
    chk("async_rst_wen", frame_wen, 0);
    chk("async_rst_scan", scan_payload, 0);
    chk("async_rst_committed", committed_count, 0);
    chk("async_rst_sb_wdata", sideband_wdata, 0);
    chk("async_rst_outputs", {frame_wrst, sideband_wen, frame_rst_wptr, dropped_count}, 0);
    @(negedge clk);
    ingress_tvalid = 0;
    reset = 1;
    exp_c = 0; exp_d = 0;
    run_frame(mk(3, 1, 0, 0, 0, 2'd2, 12'h3C0, 0, 0, 0, 3, 1));

    for (int n = 0; n < 30; n++) begin
      rv.beats   = $urandom_range(1, 8);
      rv.vat     = $urandom_range(1, rv.beats);
      rv.vdelay  = $urandom_range(0, 3);
      rv.gap     = 1'($urandom_range(0, 1));
      rv.drop    = 1'($urandom_range(0, 1));
      rv.dest    = 2'($urandom);
      rv.wptr    = 12'($urandom);
      rv.sb_full = $urandom_range(0, 3);
      rv.ff_at   = 0;
      rv.ff_len  = 0;
      if (!rv.drop && rv.beats >= 2 && $urandom_range(0, 1) == 1) begin
        rv.ff_at  = $urandom_range(1, rv.beats - 1);
        rv.ff_len = $urandom_range(1, 4);
      end
      rv.exp_writes = model_writes(rv);
      rv.exp_push   = !rv.drop;
      run_frame(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
